// File: rtl/cnn_pkg.sv
//------------------------------------------------------------------------------
// cnn_pkg : shared CNN geometry constants and weight-scheduler FSM states.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
package cnn_pkg;
   localparam int KSIZE = 25;
   localparam int N_OC  = 3;
   localparam int N_IC  = 3;
   localparam int L1_N  = 75;
   localparam int L2_N  = 225;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/kernel_slice.sv
//------------------------------------------------------------------------------
// kernel_slice : selects one 5x5 kernel (layer, oc, ic) out of the weight ROM buses.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
module kernel_slice
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                     i_layer,
   input  logic [1:0]               i_oc,
   input  logic [1:0]               i_ic,
   input  logic [DATA_W*L1_N-1:0]   i_l1_flat,
   input  logic [DATA_W*L2_N-1:0]   i_l2_flat,
   output logic [DATA_W*KSIZE-1:0]  o_kernel
);
   int w_oc_n;
   int w_ic_n;
   int w_base;

   always_comb begin
      o_kernel = '0;
      w_oc_n   = 32'(i_oc);
      w_ic_n   = 32'(i_ic);
      // Out-of-range indices fold to 0 so the part-selects can never leave the bus.
      if (w_oc_n >= N_OC) w_oc_n = 0;
      if (w_ic_n >= N_IC) w_ic_n = 0;
      w_base = i_layer ? (w_oc_n * N_IC * KSIZE + w_ic_n * KSIZE) : (w_oc_n * KSIZE);
      for (int j = 0; j < KSIZE; j++) begin
         if (i_layer)
            o_kernel[DATA_W*(KSIZE-j)-1 -: DATA_W] = i_l2_flat[DATA_W*(L2_N-(w_base+j))-1 -: DATA_W];
         else
            o_kernel[DATA_W*(KSIZE-j)-1 -: DATA_W] = i_l1_flat[DATA_W*(L1_N-(w_base+j))-1 -: DATA_W];
      end
   end
endmodule
`default_nettype wire

// File: rtl/weight_scheduler.sv
//------------------------------------------------------------------------------
// weight_scheduler : streams one layer's kernels to the MAC engine, valid/ready.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
module weight_scheduler
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     layer_sel,
   input  logic [DATA_W*L1_N-1:0]   l1_weights_flat,
   input  logic [DATA_W*L2_N-1:0]   l2_weights_flat,
   input  logic                     w_ready,
   output logic                     w_valid,
   output logic [DATA_W*KSIZE-1:0]  w_kernel,
   output logic [1:0]               w_oc,
   output logic [1:0]               w_ic,
   output logic                     w_last_ic,
   output logic                     w_last,
   output logic                     busy,
   output logic                     done
);
   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_layer;
   logic                      w_layer_nxt;
   logic                      w_hs;
   logic                      w_load;
   logic                      w_slice_layer;
   logic [1:0]                w_beat_oc;
   logic [1:0]                w_beat_ic;
   logic [DATA_W*KSIZE-1:0]   w_slice_k;
   logic                      w_nx_valid;
   logic [DATA_W*KSIZE-1:0]   w_nx_kernel;
   logic [1:0]                w_nx_oc;
   logic [1:0]                w_nx_ic;
   logic                      w_nx_last_ic;
   logic                      w_nx_last;
   logic                      w_nx_busy;
   logic                      w_nx_done;

   // The slice is always addressed with the beat about to be loaded, so the
   // registered kernel is ready in the same cycle as its indices.
   kernel_slice #(
      .DATA_W    (DATA_W)
   ) u_kernel_slice (
      .i_layer   (w_slice_layer),
      .i_oc      (w_beat_oc),
      .i_ic      (w_beat_ic),
      .i_l1_flat (l1_weights_flat),
      .i_l2_flat (l2_weights_flat),
      .o_kernel  (w_slice_k)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_layer_nxt   = r_layer;
      w_hs          = w_valid & w_ready;
      w_load        = 1'b0;
      w_slice_layer = r_layer;
      w_beat_oc     = 2'd0;
      w_beat_ic     = 2'd0;
      w_nx_valid    = w_valid;
      w_nx_oc       = w_oc;
      w_nx_ic       = w_ic;
      w_nx_last_ic  = w_last_ic;
      w_nx_last     = w_last;
      w_nx_done     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt   = ST_SEND;
               w_layer_nxt   = layer_sel;
               w_slice_layer = layer_sel;
               w_load        = 1'b1;
            end
         end
         ST_SEND: begin
            if (w_hs) begin
               if (w_last) begin
                  w_state_nxt = ST_DONE;
                  w_nx_valid  = 1'b0;
                  w_nx_done   = 1'b1;
               end else begin
                  w_load = 1'b1;
                  if (!r_layer || (w_ic == 2'(N_IC-1))) begin
                     w_beat_oc = w_oc + 2'd1;
                     w_beat_ic = 2'd0;
                  end else begin
                     w_beat_oc = w_oc;
                     w_beat_ic = w_ic + 2'd1;
                  end
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_load) begin
         w_nx_valid   = 1'b1;
         w_nx_oc      = w_beat_oc;
         w_nx_ic      = w_beat_ic;
         w_nx_last_ic = !w_slice_layer || (w_beat_ic == 2'd2);
         w_nx_last    = (w_beat_oc == 2'd2) && (w_beat_ic == (w_slice_layer ? 2'd2 : 2'd0));
      end
      w_nx_kernel = w_load ? w_slice_k : w_kernel;
      w_nx_busy   = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_layer   <= 1'b0;
         w_valid   <= 1'b0;
         w_kernel  <= '0;
         w_oc      <= 2'd0;
         w_ic      <= 2'd0;
         w_last_ic <= 1'b0;
         w_last    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_layer   <= w_layer_nxt;
         w_valid   <= w_nx_valid;
         w_kernel  <= w_nx_kernel;
         w_oc      <= w_nx_oc;
         w_ic      <= w_nx_ic;
         w_last_ic <= w_nx_last_ic;
         w_last    <= w_nx_last;
         busy      <= w_nx_busy;
         done      <= w_nx_done;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_weight_scheduler.sv
//------------------------------------------------------------------------------
// tb_weight_scheduler : randomized scoreboard bench for weight_scheduler.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
module tb_weight_scheduler;
   import cnn_pkg::*;

   localparam int DW = 8;
   localparam int KW = DW * KSIZE;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               layer_sel = 1'b0;
   logic               w_ready = 1'b1;
   logic [DW*L1_N-1:0] l1_flat;
   logic [DW*L2_N-1:0] l2_flat;
   logic               w_valid;
   logic [KW-1:0]      w_kernel;
   logic [1:0]         w_oc;
   logic [1:0]         w_ic;
   logic               w_last_ic;
   logic               w_last;
   logic               busy;
   logic               done;

   typedef struct packed {
      logic [1:0]    oc;
      logic [1:0]    ic;
      logic          lic;
      logic          last;
      logic [KW-1:0] k;
   } beat_t;

   beat_t         exp_q[$];
   logic [KW-1:0] got_k[$];
   logic [7:0]    rom1[L1_N];
   logic [7:0]    rom2[L2_N];
   int            n_cmp = 0;
   int            n_err = 0;
   int            hs_count = 0;
   int            rdy_mode = 0;
   int            rdy_cnt = 0;
   bit            done_seen = 0;
   bit            pend_done = 0;
   bit            prev_stall = 0;
   bit            prev_hs = 0;
   bit            prev_last = 0;
   logic [255:0]  held;

   weight_scheduler #(.DATA_W(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .layer_sel       (layer_sel),
      .l1_weights_flat (l1_flat),
      .l2_weights_flat (l2_flat),
      .w_ready         (w_ready),
      .w_valid         (w_valid),
      .w_kernel        (w_kernel),
      .w_oc            (w_oc),
      .w_ic            (w_ic),
      .w_last_ic       (w_last_ic),
      .w_last          (w_last),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Consumer back-pressure: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random.
   always @(posedge clk) begin
      #1;
      rdy_cnt++;
      case (rdy_mode)
         1:       w_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
         2:       w_ready = 1'($urandom_range(0, 1));
         default: w_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         pend_done  = 0;
         prev_stall = 0;
         prev_hs    = 0;
         prev_last  = 0;
      end else begin
         chk("done", 256'(done), 256'(pend_done));
         if (pend_done) begin
            chk("valid_in_done", 256'(w_valid), 256'(0));
            done_seen = 1;
         end
         pend_done = 0;
         if (prev_stall)
            chk("stall_hold", 256'({w_valid, w_oc, w_ic, w_last_ic, w_last, w_kernel}), held);
         if (prev_hs && !prev_last)
            chk("no_bubble", 256'(w_valid), 256'(1));
         if (w_valid && w_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 256'({w_oc, w_ic}), 256'(1) << 8);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat", 256'({w_oc, w_ic, w_last_ic, w_last, w_kernel}), 256'(e));
               got_k.push_back(w_kernel);
               hs_count++;
               if (w_last) pend_done = 1;
            end
         end
         prev_stall = w_valid && !w_ready;
         held       = 256'({w_valid, w_oc, w_ic, w_last_ic, w_last, w_kernel});
         prev_hs    = w_valid && w_ready;
         prev_last  = w_last;
      end
   end

   // Reference: a layer is a row-major walk over (oc, ic) with kernels cut
   // straight out of the ROM arrays.
   task automatic push_layer(input bit lay);
      int nic = lay ? N_IC : 1;
      for (int b = 0; b < N_OC * nic; b++) begin
         beat_t e;
         int oc = b / nic;
         int ic = b % nic;
         e.oc   = 2'(oc);
         e.ic   = 2'(ic);
         e.lic  = (ic == nic - 1);
         e.last = (b == N_OC * nic - 1);
         for (int j = 0; j < KSIZE; j++)
            e.k[KW-1-DW*j -: DW] = lay ? rom2[oc*75 + ic*25 + j] : rom1[oc*25 + j];
         exp_q.push_back(e);
      end
   endtask

   task automatic run_layer(input bit lay, input int mode, input int restart_at, input int rst_at);
      bit restarted = 0;
      int guard = 0;
      while (busy && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("idle_before_start", 256'(busy), 256'(0));
      @(posedge clk); #1;
      rdy_mode  = mode;
      start     = 1'b1;
      layer_sel = lay;
      hs_count  = 0;
      done_seen = 0;
      got_k.delete();
      push_layer(lay);
      @(posedge clk); #1;
      start     = 1'b0;
      layer_sel = 1'($urandom);
      chk("valid_after_start", 256'({w_valid, busy}), 256'(2'b11));
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (restart_at >= 0 && !restarted && hs_count == restart_at) begin
            start     = 1'b1;
            layer_sel = ~lay;
            restarted = 1;
         end
         if (rst_at >= 0 && hs_count == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            chk("rst_outputs", 256'({w_valid, w_kernel, w_oc, w_ic, w_last_ic, w_last, busy, done}), 256'(0));
            repeat (5) @(posedge clk);
            #1;
            chk("no_done_after_abort", 256'({done_seen, busy}), 256'(0));
            return;
         end
         if (done_seen) break;
      end
      chk("layer_done_seen", 256'(done_seen), 256'(1));
      chk("beats_delivered", 256'(hs_count), 256'(lay ? 9 : 3));
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
   endtask

   initial begin
      logic [KW-1:0] k;
      for (int i = 0; i < L1_N; i++) rom1[i] = 8'($urandom);
      for (int i = 0; i < L2_N; i++) rom2[i] = 8'($urandom);
      rom1[0]   = 8'h07;
      rom1[24]  = 8'hF6;
      rom1[25]  = 8'hBC;
      rom2[0]   = 8'h01;
      rom2[224] = 8'hDA;
      for (int i = 0; i < L1_N; i++) l1_flat[DW*(L1_N-i)-1 -: DW] = rom1[i];
      for (int i = 0; i < L2_N; i++) l2_flat[DW*(L2_N-i)-1 -: DW] = rom2[i];

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 256'({w_valid, w_kernel, w_oc, w_ic, w_last_ic, w_last, busy, done}), 256'(0));
      rst = 1'b0;

      run_layer(1'b0, 0, -1, -1);
      if (got_k.size() == 3) begin
         k = got_k[0];
         chk("l1_b0_e0", 256'(k[KW-1 -: 8]), 256'(8'h07));
         chk("l1_b0_e24", 256'(k[7:0]), 256'(8'hF6));
         k = got_k[1];
         chk("l1_b1_e0", 256'(k[KW-1 -: 8]), 256'(8'hBC));
      end else begin
         chk("l1_beat_count", 256'(got_k.size()), 256'(3));
      end

      run_layer(1'b1, 0, -1, -1);
      if (got_k.size() == 9) begin
         k = got_k[0];
         chk("l2_b0_e0", 256'(k[KW-1 -: 8]), 256'(8'h01));
         k = got_k[8];
         chk("l2_b8_e24", 256'(k[7:0]), 256'(8'hDA));
      end else begin
         chk("l2_beat_count", 256'(got_k.size()), 256'(9));
      end

      run_layer(1'b1, 1, -1, -1);
      run_layer(1'b1, 0, 4, -1);
      run_layer(1'b1, 0, -1, 5);
      run_layer(1'b0, 0, -1, -1);
      for (int r = 0; r < 6; r++)
         run_layer(1'($urandom), 2, -1, -1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/weight_scheduler.md
WEIGHT_SCHEDULER -- requirements
Module: weight_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the signed weight width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to stream one layer's kernels.
REQ-005 SHALL have port layer_sel, input, 1, layer select: 0 = layer 1, 1 = layer 2; sampled only when start is accepted.
REQ-006 SHALL have port l1_weights_flat, input, DATA_W*75, the layer-1 weight ROM bus.
REQ-007 SHALL have port l2_weights_flat, input, DATA_W*225, the layer-2 weight ROM bus.
REQ-008 SHALL have port w_ready, input, 1, consumer (MAC engine) ready.
REQ-009 SHALL have port w_valid, output, 1, kernel beat valid.
REQ-010 SHALL have port w_kernel, output, DATA_W*25, one 5x5 kernel; element j sits at bits [DATA_W*(25-j)-1 -: DATA_W], MSB-first.
REQ-011 SHALL have port w_oc, output, 2, output-channel index of the current beat.
REQ-012 SHALL have port w_ic, output, 2, input-channel index of the current beat.
REQ-013 SHALL have port w_last_ic, output, 1, high on the final input channel of an output channel.
REQ-014 SHALL have port w_last, output, 1, high on the final beat of the layer.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-017 SHALL address weight index k of a flat bus with N weights at bits [DATA_W*(N-k)-1 -: DATA_W].
REQ-018 SHALL form each kernel from weights oc*25+j (layer 1) or oc*75+ic*25+j (layer 2), for j = 0..24.
REQ-019 SHALL issue beats in the order oc 0..2 with ic as the inner loop: 3 beats for layer 1 (ic=0 always) and 9 beats for layer 2 (ic 0..2).
REQ-020 SHALL implement the FSM IDLE -> SEND on start; SEND -> DONE on the handshake of the w_last beat; DONE -> IDLE unconditionally after one cycle.
REQ-021 SHALL drive w_valid high in the cycle after start is accepted, with the beat-0 kernel already registered.
REQ-022 SHALL count a handshake when w_valid && w_ready; on each handshake the next beat's kernel and indices SHALL appear in the next cycle, with no bubble.
REQ-023 SHALL hold w_kernel, w_oc, w_ic, w_last_ic and w_last stable while w_valid && !w_ready.
REQ-024 SHALL assert w_last_ic on every layer-1 beat and on ic=2 beats in layer 2.
REQ-025 SHALL assert w_last on beat oc=2 together with ic=(layer ? 2 : 0).
REQ-026 SHALL pulse done for exactly one cycle, in DONE (the cycle after the last handshake), with w_valid low in that cycle.
REQ-027 SHALL ignore start while busy, and SHALL leave the latched layer unaffected by layer_sel changes mid-layer.
REQ-028 SHALL register all outputs; no combinational path SHALL run from w_ready to w_valid.
REQ-029 SHALL treat ROM buses as static; the kernel SHALL be sampled at beat load.

Reset
REQ-030 SHALL, with rst high at a clock edge, return to IDLE and clear w_valid, w_kernel, w_oc, w_ic, w_last_ic, w_last, busy and done to 0.
REQ-031 SHALL let rst mid-layer abort the stream with no done pulse; the next start SHALL restart from beat 0.
REQ-032 SHALL give rst priority over a simultaneous start.

Structure
REQ-033 SHALL take KSIZE=25, N_OC=3, N_IC=3, L1_N=75, L2_N=225 and the FSM state enum from the shared package cnn_pkg.
REQ-034 SHALL place slice selection in one combinational sub-module, kernel_slice, which maps (layer, oc, ic) to a 25-weight vector; counters and the FSM SHALL remain in weight_scheduler.

Verification (team weight ROM connected)
REQ-035 SHALL test start, layer_sel=0, w_ready=1: expect 3 consecutive beats; beat 0 element 0 = 0x07 and element 24 = 0xF6 (-10); beat 1 element 0 = 0xBC (-68); w_last on beat 2; done the following cycle.
REQ-036 SHALL test start, layer_sel=1, w_ready=1: expect 9 beats with (oc,ic) = (0,0)..(2,2); beat (0,0) element 0 = 0x01; beat (2,2) element 24 = 0xDA (-38); w_last_ic on beats 2, 5 and 8.
REQ-037 SHALL test layer 2 with w_ready toggling 1-0-0-1 repeatedly: outputs are stable during stalls; all 9 beats delivered exactly once; done pulses for one cycle.
REQ-038 SHALL test start pulsed again during beat 4 with layer_sel flipped: no restart; the layer-2 sequence completes unchanged.
REQ-039 SHALL test rst asserted at layer-2 beat 5, then a new start with layer_sel=0: all outputs 0 after the rst edge; no done; the fresh layer-1 stream begins at oc=0.
